handshake_skid_fifo: RTL and testbench

//  Parametrised valid/ready buffer: generalises the single-slot up/down handshake stage to DEPTH entries.

---
 rtl/handshake_skid_fifo.sv | 59 +++++
 tb/tb_handshake_skid_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/handshake_skid_fifo.sv
// Valid/ready stream buffer of DEPTH entries with occupancy count, almost-full flag and synchronous flush.
// Every output is derived from registered state, so down_ready never combinationally reaches up_ready.
module handshake_skid_fifo #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [CW-1:0]         count,
  output logic                  almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the sender holds valid/data stable until that edge.
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  assign up_ready    = !rst && (count != FULL_COUNT);
  assign down_valid  = (count != '0);
  assign down_data   = down_valid ? mem[rd_ptr] : '0;
  assign almost_full = (count >= AF_COUNT);

  assign push = up_valid && up_ready;
  assign pop  = down_valid && down_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset; a flushed push is simply never made visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= up_data;
  end

endmodule

// File: tb/tb_handshake_skid_fifo.sv
// Directed bench for handshake_skid_fifo: a vector table for reset/fill/drain/flush,
// then streaming and stalled-downstream sequences checked against an in-order scoreboard.
module tb_handshake_skid_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic [W-1:0]  up_data;
  logic          up_ready;
  logic          down_valid;
  logic [W-1:0]  down_data;
  logic          down_ready;
  logic [CW-1:0] count;
  logic          almost_full;

  handshake_skid_fifo #(.WORD_WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, flush, uv;
    logic [W-1:0] ud;
    logic         dr;
    logic         chk;
    logic         ur, dv;
    logic [W-1:0] dd;
    logic [CW-1:0] cnt;
    logic         af;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           model_cnt;
  int           pops;
  int           pushes;
  logic         last_push;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic uv, input logic [W-1:0] ud,
                     input logic dr, input logic chk, input logic ur, input logic dv,
                     input logic [W-1:0] dd, input logic [CW-1:0] cnt, input logic af);
    vec_t v;
    v.rst = r; v.flush = f; v.uv = uv; v.ud = ud; v.dr = dr; v.chk = chk;
    v.ur = ur; v.dv = dv; v.dd = dd; v.cnt = cnt; v.af = af;
    vecs.push_back(v);
  endtask

  // Drive one cycle, compare against the model, update scoreboard and model.
  task automatic stream_step(input logic uv, input logic [W-1:0] d, input logic dr);
    logic push, pop;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; up_valid = uv; up_data = d; down_ready = dr;
    #1;
    check("s_count", 32'(count), 32'(model_cnt));
    check("s_down_valid", 32'(down_valid), 32'(model_cnt != 0));
    check("s_up_ready", 32'(up_ready), 32'(model_cnt != DEPTH));
    push = uv && up_ready;
    pop  = down_valid && dr;
    if (pop) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL s_pop_empty: got 0x%0h expected no pop", down_data);
      end else begin
        check("s_data", 32'(down_data), 32'(exp_q.pop_front()));
      end
      pops++;
    end
    if (push) begin
      exp_q.push_back(d);
      pushes++;
    end
    last_push = push;
    model_cnt = model_cnt + int'(push) - int'(pop);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;

    // rst flush uv data dr | chk ur dv dd cnt af   (expected = outputs before the edge)
    add(1,0,1,8'h00,0, 0, 0,0,8'h00,0,0);  // before first reset edge
    add(1,0,1,8'h00,0, 1, 0,0,8'h00,0,0);  // after first reset edge
    add(0,0,0,8'h00,0, 1, 1,0,8'h00,0,0);  // released
    add(0,0,1,8'h11,0, 1, 1,0,8'h00,0,0);  // fill with stalled downstream
    add(0,0,1,8'h22,0, 1, 1,1,8'h11,1,0);
    add(0,0,1,8'h33,0, 1, 1,1,8'h11,2,0);
    add(0,0,1,8'h44,0, 1, 1,1,8'h11,3,1);
    add(0,0,1,8'h55,0, 1, 0,1,8'h11,4,1);  // full: offer refused
    add(0,0,0,8'h00,1, 1, 0,1,8'h11,4,1);  // drain
    add(0,0,0,8'h00,1, 1, 1,1,8'h22,3,1);
    add(0,0,0,8'h00,1, 1, 1,1,8'h33,2,0);
    add(0,0,0,8'h00,1, 1, 1,1,8'h44,1,0);
    add(0,0,0,8'h00,0, 1, 1,0,8'h00,0,0);
    add(0,0,1,8'ha1,0, 1, 1,0,8'h00,0,0);  // refill for flush at full
    add(0,0,1,8'ha2,0, 1, 1,1,8'ha1,1,0);
    add(0,0,1,8'ha3,0, 1, 1,1,8'ha1,2,0);
    add(0,0,1,8'ha4,0, 1, 1,1,8'ha1,3,1);
    add(0,1,1,8'h55,1, 1, 0,1,8'ha1,4,1);  // flush with pop offered
    add(0,0,1,8'h66,0, 1, 1,0,8'h00,0,0);
    add(0,0,0,8'h00,0, 1, 1,1,8'h66,1,0);  // sole entry
    add(0,0,0,8'h00,1, 1, 1,1,8'h66,1,0);
    add(0,1,1,8'h77,0, 1, 1,0,8'h00,0,0);  // flush drops an accepted push
    add(0,0,1,8'h88,0, 1, 1,0,8'h00,0,0);
    add(0,0,1,8'h99,0, 1, 1,1,8'h88,1,0);
    add(1,0,1,8'h12,0, 1, 0,1,8'h88,2,0);  // reset mid-operation
    add(0,0,0,8'h00,0, 1, 1,0,8'h00,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; up_valid = vecs[i].uv;
      up_data = vecs[i].ud; down_ready = vecs[i].dr;
      #1;
      check($sformatf("v%0d_up_ready", i), 32'(up_ready), 32'(vecs[i].ur));
      if (vecs[i].chk) begin
        check($sformatf("v%0d_down_valid", i), 32'(down_valid), 32'(vecs[i].dv));
        check($sformatf("v%0d_down_data", i), 32'(down_data), 32'(vecs[i].dd));
        check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
        check($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      end
    end

    // Streaming with both sides always ready, spanning several pointer wraps.
    model_cnt = 0; pops = 0; pushes = 0; exp_q.delete();
    for (int i = 0; i < 32; i++) stream_step(1'b1, W'(i), 1'b1);
    for (int k = 0; k < 8 && model_cnt != 0; k++) stream_step(1'b0, '0, 1'b1);
    check("stream_pops", 32'(pops), 32'd32);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    // Downstream toggling while the source always offers random data.
    pops = 0; pushes = 0;
    d = W'($urandom_range(0, 255));
    for (int c = 0; c < 40; c++) begin
      stream_step(1'b1, d, c[0]);
      if (last_push) d = W'($urandom_range(0, 255));
    end
    for (int k = 0; k < 8 && model_cnt != 0; k++) stream_step(1'b0, '0, 1'b1);
    check("toggle_balance", 32'(pops), 32'(pushes));
    check("toggle_left", 32'(exp_q.size()), 32'd0);
    check("toggle_min_traffic", 32'(pushes >= 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
